// File: rtl/int_alu_pkg.sv
// Shared types for the chunked integer add/subtract datapath.
package int_alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic neg;
    } alu_flags_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit adder chunk: sum = a + b + cin, with carry out.
module chunk_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/int_addsub_pipe.sv
// Two-stage add/subtract: low chunk and its carry in stage 1, high chunk and
// result flags in stage 2, valid/ready with full backpressure on both sides.
module int_addsub_pipe
    import int_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int HALF = WIDTH / 2;

    function automatic logic signed_overflow(
        input logic signed [HALF-1:0] a_hi,
        input logic signed [HALF-1:0] b_hi,
        input logic signed [HALF-1:0] r_hi
    );
        return ((a_hi < 0) == (b_hi < 0)) && ((r_hi < 0) != (a_hi < 0));
    endfunction

    logic                    vld_p1_q, vld_p1_d;
    logic [HALF-1:0]         lo_p1_q, lo_p1_d;
    logic                    c_p1_q, c_p1_d;
    logic                    lo_zero_p1_q, lo_zero_p1_d;
    logic signed [HALF-1:0]  a_hi_p1_q, a_hi_p1_d;
    logic signed [HALF-1:0]  b_hi_p1_q, b_hi_p1_d;
    logic [TAG_W-1:0]        tag_p1_q, tag_p1_d;

    logic                    vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0]        result_p2_q, result_p2_d;
    logic [TAG_W-1:0]        tag_p2_q, tag_p2_d;
    alu_flags_t              flags_p2_q, flags_p2_d;

    logic                    s2_ready, accept, advance;

    // stage 0: operand conditioning and low-chunk sum
    alu_op_e                 op_p0;
    logic [WIDTH-1:0]        b_eff_p0;
    logic                    cin_p0;
    logic [HALF-1:0]         lo_sum_p0;
    logic                    lo_cout_p0;

    always_comb begin
        op_p0    = alu_op_e'(in_op);
        cin_p0   = (op_p0 == OP_SUB);
        b_eff_p0 = cin_p0 ? ~in_b : in_b;
    end

    chunk_adder #(.W(HALF)) u_lo_adder (
        .a    (in_a[HALF-1:0]),
        .b    (b_eff_p0[HALF-1:0]),
        .cin  (cin_p0),
        .sum  (lo_sum_p0),
        .cout (lo_cout_p0)
    );

    always_comb begin
        s2_ready = !vld_p2_q || out_ready;
        in_ready = !vld_p1_q || s2_ready;
        accept   = in_valid && in_ready;
        advance  = vld_p1_q && s2_ready;
    end

    always_comb begin
        vld_p1_d     = accept ? 1'b1 : (advance ? 1'b0 : vld_p1_q);
        lo_p1_d      = lo_p1_q;
        c_p1_d       = c_p1_q;
        lo_zero_p1_d = lo_zero_p1_q;
        a_hi_p1_d    = a_hi_p1_q;
        b_hi_p1_d    = b_hi_p1_q;
        tag_p1_d     = tag_p1_q;
        if (accept) begin
            lo_p1_d      = lo_sum_p0;
            c_p1_d       = lo_cout_p0;
            lo_zero_p1_d = (lo_sum_p0 == '0);
            a_hi_p1_d    = in_a[WIDTH-1:HALF];
            b_hi_p1_d    = b_eff_p0[WIDTH-1:HALF];
            tag_p1_d     = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        lo_p1_q      <= lo_p1_d;
        c_p1_q       <= c_p1_d;
        lo_zero_p1_q <= lo_zero_p1_d;
        a_hi_p1_q    <= a_hi_p1_d;
        b_hi_p1_q    <= b_hi_p1_d;
        tag_p1_q     <= tag_p1_d;
    end

    // stage 1 -> 2: high-chunk sum with the registered low carry, then flags
    logic [HALF-1:0]         hi_sum_p1;
    logic                    hi_cout_p1;
    alu_flags_t              flags_p1;

    chunk_adder #(.W(HALF)) u_hi_adder (
        .a    (a_hi_p1_q),
        .b    (b_hi_p1_q),
        .cin  (c_p1_q),
        .sum  (hi_sum_p1),
        .cout (hi_cout_p1)
    );

    always_comb begin
        flags_p1.carry    = hi_cout_p1;
        flags_p1.overflow = signed_overflow(a_hi_p1_q, b_hi_p1_q, hi_sum_p1);
        flags_p1.zero     = lo_zero_p1_q && (hi_sum_p1 == '0);
        flags_p1.neg      = hi_sum_p1[HALF-1];
    end

    always_comb begin
        vld_p2_d    = advance || (vld_p2_q && !out_ready);
        result_p2_d = result_p2_q;
        tag_p2_d    = tag_p2_q;
        flags_p2_d  = flags_p2_q;
        if (advance) begin
            result_p2_d = {hi_sum_p1, lo_p1_q};
            tag_p2_d    = tag_p1_q;
            flags_p2_d  = flags_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q    <= 1'b0;
            result_p2_q <= '0;
            tag_p2_q    <= '0;
            flags_p2_q  <= '0;
        end else begin
            vld_p2_q    <= vld_p2_d;
            result_p2_q <= result_p2_d;
            tag_p2_q    <= tag_p2_d;
            flags_p2_q  <= flags_p2_d;
        end
    end

    assign out_valid    = vld_p2_q;
    assign out_result   = result_p2_q;
    assign out_tag      = tag_p2_q;
    assign out_carry    = flags_p2_q.carry;
    assign out_overflow = flags_p2_q.overflow;
    assign out_zero     = flags_p2_q.zero;
    assign out_neg      = flags_p2_q.neg;

endmodule

// File: tb/tb_int_addsub_pipe.sv
// Self-checking bench for int_addsub_pipe with a plain-arithmetic reference model.
module tb_int_addsub_pipe;

    localparam int W  = 32;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          c;
        logic          v;
        logic          z;
        logic          n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_op = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_carry, out_overflow, out_zero, out_neg;
    exp_t          act;

    int n_checks = 0;
    int n_fail   = 0;

    int_addsub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_neg      (out_neg)
    );

    always #5 clk = ~clk;

    always_comb act = {out_result, out_tag, out_carry, out_overflow, out_zero, out_neg};

    // Reference: exact signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TW-1:0] tag);
        exp_t e;
        longint sa, sb, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        if (op) begin
            e.res = a - b;
            e.c   = (a >= b);
            sr    = sa - sb;
        end else begin
            e.res = a + b;
            e.c   = (ua + ub) >= 64'h1_0000_0000;
            sr    = sa + sb;
        end
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_one(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (act !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", act);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_carry_boundary();
        exp_t e;
        e = {32'h0001_0000, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL carry_in_ready: got %b expected 1", in_ready);
        end
        drive_one(1'b0, 32'h0000_FFFF, 32'h0000_0001, 4'h3);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL carry_latency1: got %b expected 0", out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL carry_latency2: got %b expected 1", out_valid);
        end
        n_checks++;
        if (act !== e) begin
            n_fail++; $display("FAIL carry_result: got %h expected %h", act, e);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL carry_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sub_zero();
        exp_t e;
        e = {32'h0000_0000, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        drive_one(1'b1, 32'h1234_5678, 32'h1234_5678, 4'h5);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, act} !== {1'b1, e}) begin
            n_fail++; $display("FAIL sub_zero: got %b/%h expected 1/%h", out_valid, act, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_borrow_overflow();
        logic          ops [4];
        logic [W-1:0]  as  [4];
        logic [W-1:0]  bs  [4];
        exp_t          es  [4];
        ops[0] = 1'b1; as[0] = 32'h0000_0000; bs[0] = 32'h0000_0001;
        es[0]  = {32'hFFFF_FFFF, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1};
        ops[1] = 1'b0; as[1] = 32'h7FFF_FFFF; bs[1] = 32'h0000_0001;
        es[1]  = {32'h8000_0000, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1};
        ops[2] = 1'b0; as[2] = 32'hFFFF_FFFF; bs[2] = 32'h0000_0001;
        es[2]  = {32'h0000_0000, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0};
        ops[3] = 1'b1; as[3] = 32'h8000_0000; bs[3] = 32'h0000_0001;
        es[3]  = {32'h7FFF_FFFF, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_one(ops[i], as[i], bs[i], 4'(6 + i));
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, act} !== {1'b1, es[i]}) begin
                n_fail++;
                $display("FAIL boundary_%0d: got %b/%h expected 1/%h", i, out_valid, act, es[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t          q[$];
        exp_t          snap, e;
        logic          op [5];
        logic [W-1:0]  a   [5];
        logic [W-1:0]  b   [5];
        int            sent, got, cyc, last;
        for (int i = 0; i < 5; i++) begin
            op[i] = 1'($urandom_range(0, 1));
            a[i]  = rnd_operand();
            b[i]  = rnd_operand();
        end
        out_ready = 1'b0;
        sent = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_op = op[sent]; in_a = a[sent]; in_b = b[sent];
            in_tag = 4'(sent + 1);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_accept_%0d: got %b expected 1", k, in_ready);
            end
            q.push_back(model(in_op, in_a, in_b, in_tag));
            sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_op = op[2]; in_a = a[2]; in_b = b[2]; in_tag = 4'd3;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready_drop: got %b expected 0", in_ready);
        end
        n_checks++;
        if ({out_valid, act} !== {1'b1, q[0]}) begin
            n_fail++; $display("FAIL bp_head: got %b/%h expected 1/%h", out_valid, act, q[0]);
        end
        snap = act;
        repeat (4) begin
            @(posedge clk); #1;
            n_checks++;
            if ({in_ready, out_valid, act} !== {1'b0, 1'b1, snap}) begin
                n_fail++;
                $display("FAIL bp_hold: got %b%b/%h expected 01/%h", in_ready, out_valid, act, snap);
            end
        end
        out_ready = 1'b1;
        got = 0; cyc = 0; last = -1;
        while (got < 5 && cyc < 40) begin
            if (sent < 5) begin
                in_valid = 1'b1; in_op = op[sent]; in_a = a[sent]; in_b = b[sent];
                in_tag = 4'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_unexpected: got tag %0d expected none", out_tag);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        n_fail++; $display("FAIL bp_drain: got %h expected %h", act, e);
                    end
                    if (last >= 0) begin
                        n_checks++;
                        if (cyc !== last + 1) begin
                            n_fail++; $display("FAIL bp_no_bubble: got cycle %0d expected %0d", cyc, last + 1);
                        end
                    end
                    last = cyc;
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_op, in_a, in_b, in_tag));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 5) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 5", got);
        end
    endtask

    task automatic test_throughput();
        exp_t q[$];
        exp_t e;
        int   sent, got, cyc, last;
        out_ready = 1'b1;
        sent = 0; got = 0; cyc = 0; last = -1;
        while (got < 100 && cyc < 300) begin
            if (sent < 100) begin
                in_valid = 1'b1;
                in_op    = 1'($urandom_range(0, 1));
                in_a     = rnd_operand();
                in_b     = rnd_operand();
                in_tag   = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL tput_in_ready: got %b expected 1 at op %0d", in_ready, sent);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL tput_unexpected: got %h expected none", act);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        n_fail++; $display("FAIL tput_result_%0d: got %h expected %h", got, act, e);
                    end
                    if (last >= 0) begin
                        n_checks++;
                        if (cyc !== last + 1) begin
                            n_fail++; $display("FAIL tput_bubble: got cycle %0d expected %0d", cyc, last + 1);
                        end
                    end
                    last = cyc;
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_op, in_a, in_b, in_tag));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 100) begin
            n_fail++; $display("FAIL tput_count: got %0d expected 100", got);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive_one(1'b0, 32'h1111_1111, 32'h2222_2222, 4'hA);
        drive_one(1'b1, 32'h5555_5555, 32'h1111_1111, 4'hB);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rst_mid_full: got %b%b expected 10", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, act} !== '0) begin
            n_fail++; $display("FAIL rst_mid_async: got %b/%h expected 0/0", out_valid, act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++; $display("FAIL rst_mid_stale_%0d: got %b%b expected 01", i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_carry_boundary();
        test_sub_zero();
        test_borrow_overflow();
        test_backpressure();
        test_throughput();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_addsub_pipe.md
Name: int_addsub_pipe

Overview:
- Two-stage pipelined integer add/subtract unit built from two half-width chunks.
- Stage 1 computes the low half and its carry. Stage 2 computes the upper half from the registered carry and produces the result flags.
- Sits between the operand-issue logic (upstream) and integer writeback (downstream).
- Uses valid/ready handshakes on both sides, with full backpressure support.

Parameters:
- WIDTH, 32: operand and result width; must be even and at least 4.
- HALF, WIDTH/2: chunk width; derived, never overridden.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operation is present.
- in_ready  out  1  block accepts an operation this cycle.
- in_op  in  1  0 = add, 1 = subtract (a - b).
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_tag  in  TAG_W  opaque tag; returned unchanged with the result.
- out_valid  out  1  result is present.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- out_tag  out  TAG_W  tag of the result.
- out_carry  out  1  carry out of the MSB; for subtract, 1 means no borrow (a >= b unsigned).
- out_overflow  out  1  signed overflow.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].

Behaviour:
- Arithmetic:
  - Subtract is implemented as a + ~b + 1.
  - Effective b is b' = in_op ? ~in_b : in_b; carry-in of the low chunk is cin0 = in_op.
- Stage 1 (registered on accept):
  - s1_lo = a[HALF-1:0] + b'[HALF-1:0] + cin0, truncated to HALF bits.
  - s1_c = carry out of that sum.
  - s1_lo_zero = (s1_lo == 0).
  - Also stores a[WIDTH-1:HALF], b'[WIDTH-1:HALF], tag and s1_valid.
- Stage 2 (registered on advance):
  - hi = s1_a_hi + s1_b_hi + s1_c.
  - out_result = {hi, s1_lo}; out_carry = carry out of the hi sum.
  - out_overflow = (a_msb == b'_msb) && (result_msb != a_msb).
  - out_zero = s1_lo_zero && (hi == 0); out_neg = result MSB.
- Handshake:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready, combinational, with no dependency on in_valid.
  - Stage 1 loads when in_valid && in_ready.
  - Stage 2 loads when s1_valid && s2_ready.
  - s1_valid clears when stage 1 advances and no new accept occurs in the same cycle.
- Latency and throughput:
  - 2 cycles from accept to out_valid.
  - Sustained throughput of 1 operation per cycle when out_ready stays high.
- Stalls:
  - While out_valid && !out_ready, all out_* signals hold stable and stage 2 does not change.
  - Stage 1 holds when occupied; in_ready drops only when both stages are full and the output is stalled.
- Simultaneous events: out handshake, stage-1 advance and input accept in the same cycle are all legal, with no bubble inserted.
- Reset (asynchronous, active-low):
  - s1_valid = 0, out_valid = 0.
  - out_result, out_tag and all flags = 0.
  - in_ready reads 1 once reset is released.
  - Any in-flight operations are discarded on assertion mid-operation, with no partial output.
- Data registers without a valid need no reset, apart from the output registers listed above.
- Boundaries:
  - Wrap-around is modulo 2^WIDTH.
  - Carry from bit HALF-1 must propagate through the stage boundary (e.g. 0x0000FFFF + 1).
  - Stage-2 data is never overwritten while out_valid && !out_ready.

Decomposition:
- Shared package int_alu_pkg contains:
  - typedef alu_op_e (OP_ADD = 0, OP_SUB = 1).
  - struct alu_flags_t {carry, overflow, zero, neg}.
  - localparam default width 32.
- One natural sub-module, chunk_adder: HALF-bit a + b + cin giving sum and cout, combinational.
  - Instantiated once per stage.
  - Also reusable by the existing chunked adder/subtractor.

Test Plan:
- Carry across the chunk boundary: add 0x0000FFFF + 0x00000001 -> result 0x00010000, carry 0, zero 0, 2 cycles after accept.
- Subtract to zero: sub 0x12345678 - 0x12345678 -> result 0, zero 1, carry 1, overflow 0.
- Borrow and overflow:
  - sub 0x00000000 - 0x00000001 -> 0xFFFFFFFF, carry 0, neg 1.
  - add 0x7FFFFFFF + 1 -> 0x80000000, overflow 1.
- Backpressure: issue tags 1..5 back-to-back, hold out_ready = 0 for 4 cycles.
  - in_ready drops after 2 accepts; outputs stay stable.
  - After release, tags 1..5 emerge in order, 1 per cycle, with correct results.
- Full throughput: 100 random ops with in_valid and out_ready held at 1.
  - One result per cycle, no bubbles, all results match a reference model.
- Reset mid-flight: assert rst_n = 0 with both stages full.
  - out_valid = 0 and outputs = 0 immediately (asynchronous).
  - After release, no stale result appears and in_ready = 1.
